// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcodes, funct codes, ALU operation codes,
// operand-source codes and the decoded-instruction bundle.
package decode_stage_pkg;

    localparam int ENABLE  = 1;
    localparam int DISABLE = 0;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 for arithmetic / logic
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for loads / stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct7
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation codes; ALU_NOP must stay zero so a cleared entry reads as NOP.
    // ALU_MUL..ALU_REMU are consecutive in funct3 order.
    localparam logic [5:0] ALU_NOP    = 6'd0;
    localparam logic [5:0] ALU_ADD    = 6'd1;
    localparam logic [5:0] ALU_SUB    = 6'd2;
    localparam logic [5:0] ALU_SLL    = 6'd3;
    localparam logic [5:0] ALU_SLT    = 6'd4;
    localparam logic [5:0] ALU_SLTU   = 6'd5;
    localparam logic [5:0] ALU_XOR    = 6'd6;
    localparam logic [5:0] ALU_SRL    = 6'd7;
    localparam logic [5:0] ALU_SRA    = 6'd8;
    localparam logic [5:0] ALU_OR     = 6'd9;
    localparam logic [5:0] ALU_AND    = 6'd10;
    localparam logic [5:0] ALU_BEQ    = 6'd11;
    localparam logic [5:0] ALU_BNE    = 6'd12;
    localparam logic [5:0] ALU_BLT    = 6'd13;
    localparam logic [5:0] ALU_BGE    = 6'd14;
    localparam logic [5:0] ALU_BLTU   = 6'd15;
    localparam logic [5:0] ALU_BGEU   = 6'd16;
    localparam logic [5:0] ALU_LB     = 6'd17;
    localparam logic [5:0] ALU_LH     = 6'd18;
    localparam logic [5:0] ALU_LW     = 6'd19;
    localparam logic [5:0] ALU_LBU    = 6'd20;
    localparam logic [5:0] ALU_LHU    = 6'd21;
    localparam logic [5:0] ALU_SB     = 6'd22;
    localparam logic [5:0] ALU_SH     = 6'd23;
    localparam logic [5:0] ALU_SW     = 6'd24;
    localparam logic [5:0] ALU_JAL    = 6'd25;
    localparam logic [5:0] ALU_JALR   = 6'd26;
    localparam logic [5:0] ALU_LUI    = 6'd27;
    localparam logic [5:0] ALU_MUL    = 6'd28;
    localparam logic [5:0] ALU_MULH   = 6'd29;
    localparam logic [5:0] ALU_MULHSU = 6'd30;
    localparam logic [5:0] ALU_MULHU  = 6'd31;
    localparam logic [5:0] ALU_DIV    = 6'd32;
    localparam logic [5:0] ALU_DIVU   = 6'd33;
    localparam logic [5:0] ALU_REM    = 6'd34;
    localparam logic [5:0] ALU_REMU   = 6'd35;

    // ALU operand sources
    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    // Everything decoded from one instruction except the immediate,
    // whose width follows the stage's XLEN.
    typedef struct packed {
        logic [4:0] srcreg1_num;
        logic [4:0] srcreg2_num;
        logic [4:0] dstreg_num;
        logic [5:0] alucode;
        logic [1:0] aluop1_type;
        logic [1:0] aluop2_type;
        logic       reg_we;
        logic       is_load;
        logic       is_store;
        logic       is_halt;
        logic       is_illegal;
    } decode_t;

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I(+M) decoder: instruction word in, decoded
// bundle and sign-extended immediate out. Halt is recognised by the wrapper.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_M = 1,
    parameter int XLEN     = 32
) (
    input  logic [31:0]     ir_i,
    output decode_t         dec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immRaw;
    decode_t     dec;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];

    // Decode by opcode, then squash side effects of anything flagged illegal
    always_comb begin
        dec         = '0;
        dec.alucode = ALU_NOP;
        immRaw      = '0;
        case (opcode)
            OPC_OPIMM: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_REG;
                dec.aluop2_type = OP_TYPE_IMM;
                dec.reg_we      = 1'b1;
                immRaw          = {{20{ir_i[31]}}, ir_i[31:20]};
                case (funct3)
                    F3_ADD:  dec.alucode = ALU_ADD;
                    F3_SLT:  dec.alucode = ALU_SLT;
                    F3_SLTU: dec.alucode = ALU_SLTU;
                    F3_XOR:  dec.alucode = ALU_XOR;
                    F3_OR:   dec.alucode = ALU_OR;
                    F3_AND:  dec.alucode = ALU_AND;
                    F3_SLL: begin
                        immRaw = {27'b0, ir_i[24:20]};
                        if (funct7 == F7_BASE) dec.alucode    = ALU_SLL;
                        else                   dec.is_illegal = 1'b1;
                    end
                    default: begin
                        immRaw = {27'b0, ir_i[24:20]};
                        if (funct7 == F7_BASE)     dec.alucode    = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.alucode    = ALU_SRA;
                        else                       dec.is_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.srcreg2_num = ir_i[24:20];
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_REG;
                dec.aluop2_type = OP_TYPE_REG;
                dec.reg_we      = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            F3_ADD:  dec.alucode = ALU_ADD;
                            F3_SLL:  dec.alucode = ALU_SLL;
                            F3_SLT:  dec.alucode = ALU_SLT;
                            F3_SLTU: dec.alucode = ALU_SLTU;
                            F3_XOR:  dec.alucode = ALU_XOR;
                            F3_SR:   dec.alucode = ALU_SRL;
                            F3_OR:   dec.alucode = ALU_OR;
                            default: dec.alucode = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == F3_ADD)     dec.alucode    = ALU_SUB;
                        else if (funct3 == F3_SR) dec.alucode    = ALU_SRA;
                        else                      dec.is_illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M == ENABLE) dec.alucode    = ALU_MUL + {3'b000, funct3};
                        else                    dec.is_illegal = 1'b1;
                    end
                    default: dec.is_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_NONE;
                dec.aluop2_type = OP_TYPE_IMM;
                dec.reg_we      = 1'b1;
                dec.alucode     = ALU_LUI;
                immRaw          = {ir_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_PC;
                dec.aluop2_type = OP_TYPE_IMM;
                dec.reg_we      = 1'b1;
                dec.alucode     = ALU_ADD;
                immRaw          = {ir_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_PC;
                dec.aluop2_type = OP_TYPE_NONE;
                dec.reg_we      = 1'b1;
                dec.alucode     = ALU_JAL;
                immRaw          = {{12{ir_i[31]}}, ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_PC;
                dec.aluop2_type = OP_TYPE_NONE;
                dec.reg_we      = 1'b1;
                dec.alucode     = ALU_JALR;
                dec.is_illegal  = (funct3 != 3'b000);
                immRaw          = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OPC_BRANCH: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.srcreg2_num = ir_i[24:20];
                dec.aluop1_type = OP_TYPE_REG;
                dec.aluop2_type = OP_TYPE_REG;
                immRaw          = {{20{ir_i[31]}}, ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
                case (funct3)
                    F3_BEQ:  dec.alucode    = ALU_BEQ;
                    F3_BNE:  dec.alucode    = ALU_BNE;
                    F3_BLT:  dec.alucode    = ALU_BLT;
                    F3_BGE:  dec.alucode    = ALU_BGE;
                    F3_BLTU: dec.alucode    = ALU_BLTU;
                    F3_BGEU: dec.alucode    = ALU_BGEU;
                    default: dec.is_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.dstreg_num  = ir_i[11:7];
                dec.aluop1_type = OP_TYPE_REG;
                dec.aluop2_type = OP_TYPE_IMM;
                dec.reg_we      = 1'b1;
                dec.is_load     = 1'b1;
                immRaw          = {{20{ir_i[31]}}, ir_i[31:20]};
                case (funct3)
                    F3_B:    dec.alucode    = ALU_LB;
                    F3_H:    dec.alucode    = ALU_LH;
                    F3_W:    dec.alucode    = ALU_LW;
                    F3_BU:   dec.alucode    = ALU_LBU;
                    F3_HU:   dec.alucode    = ALU_LHU;
                    default: dec.is_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.srcreg1_num = ir_i[19:15];
                dec.srcreg2_num = ir_i[24:20];
                dec.aluop1_type = OP_TYPE_REG;
                dec.aluop2_type = OP_TYPE_IMM;
                dec.is_store    = 1'b1;
                immRaw          = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
                case (funct3)
                    F3_B:    dec.alucode    = ALU_SB;
                    F3_H:    dec.alucode    = ALU_SH;
                    F3_W:    dec.alucode    = ALU_SW;
                    default: dec.is_illegal = 1'b1;
                endcase
            end
            default: dec.is_illegal = 1'b1;
        endcase

        if (dec.is_illegal) begin
            dec.reg_we   = 1'b0;
            dec.is_load  = 1'b0;
            dec.is_store = 1'b0;
            dec.alucode  = ALU_NOP;
        end
    end

    assign dec_o = dec;
    assign imm_o = XLEN'($signed(immRaw));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes the incoming instruction, holds results in
// a small FIFO between fetch and execute, latches halt and supports flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          ENABLE_M = 1,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] HALT_IR  = 32'h00000073,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      srcreg1_num,
    output logic [4:0]      srcreg2_num,
    output logic [4:0]      dstreg_num,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      alucode,
    output logic [1:0]      aluop1_type,
    output logic [1:0]      aluop2_type,
    output logic            reg_we,
    output logic            is_load,
    output logic            is_store,
    output logic            is_halt,
    output logic            is_illegal,
    output logic            halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    decode_t         decoded;
    decode_t         pushEntry;
    logic [XLEN-1:0] decodedImm;
    logic [XLEN-1:0] pushImm;
    logic            isHalt;
    logic            push;
    logic            pop;

    decode_t         entry_q [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) return '0;
        return ptr + 1'b1;
    endfunction

    function automatic decode_t emptyEntry();
        decode_t e;
        e         = '0;
        e.alucode = ALU_NOP;
        return e;
    endfunction

    decode_comb #(
        .ENABLE_M (ENABLE_M),
        .XLEN     (XLEN)
    ) u_decode (
        .ir_i  (in_ir),
        .dec_o (decoded),
        .imm_o (decodedImm)
    );

    assign isHalt    = (in_ir == HALT_IR);
    assign out_valid = (count_q != '0);
    assign in_ready  = !halted_q && !flush &&
                       ((count_q < CNT_W'(DEPTH)) || (out_valid && out_ready));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The halt word becomes a plain legal entry carrying only is_halt
    always_comb begin
        pushEntry = decoded;
        pushImm   = decodedImm;
        if (isHalt) begin
            pushEntry         = emptyEntry();
            pushEntry.is_halt = 1'b1;
            pushImm           = '0;
        end
    end

    // Queue bookkeeping and halt latch; flush empties everything and clears halt
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            wrPtr_d  = '0;
            rdPtr_d  = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (push) wrPtr_d = nextPtr(wrPtr_q);
            if (pop)  rdPtr_d = nextPtr(rdPtr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (push && isHalt) halted_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Queue storage; cleared on reset so the head reads as an empty NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= emptyEntry();
                imm_q[i]   <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            entry_q[wrPtr_q] <= pushEntry;
            imm_q[wrPtr_q]   <= pushImm;
            pc_q[wrPtr_q]    <= in_pc;
        end
    end

    assign out_pc      = pc_q[rdPtr_q];
    assign imm         = imm_q[rdPtr_q];
    assign srcreg1_num = entry_q[rdPtr_q].srcreg1_num;
    assign srcreg2_num = entry_q[rdPtr_q].srcreg2_num;
    assign dstreg_num  = entry_q[rdPtr_q].dstreg_num;
    assign alucode     = entry_q[rdPtr_q].alucode;
    assign aluop1_type = entry_q[rdPtr_q].aluop1_type;
    assign aluop2_type = entry_q[rdPtr_q].aluop2_type;
    assign reg_we      = entry_q[rdPtr_q].reg_we;
    assign is_load     = entry_q[rdPtr_q].is_load;
    assign is_store    = entry_q[rdPtr_q].is_store;
    assign is_halt     = entry_q[rdPtr_q].is_halt;
    assign is_illegal  = entry_q[rdPtr_q].is_illegal;
    assign halted      = halted_q;

endmodule
